// File: rtl/button_event_decoder_pkg.sv
// button_event_decoder_pkg: shared gesture state type and counter sizing helper
//   t_Button_State : gesture states of the decoder
//   cnt_width      : bits needed to count up to the largest of three limits
package button_event_decoder_pkg;

    typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, HELD} t_Button_State;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// button_event_decoder_if: debounced button level in, gesture pulses out
//   i_Switch                            : debounced level, 1 = pressed
//   o_Click/o_Double_Click/o_Long_Press : one-cycle gesture pulses
//   o_Repeat                            : periodic pulse while a long press is held
//   o_Busy                              : a gesture is in progress
interface button_event_decoder_if;

    logic i_Switch;
    logic o_Click;
    logic o_Double_Click;
    logic o_Long_Press;
    logic o_Repeat;
    logic o_Busy;

    modport master (
        output i_Switch,
        input  o_Click, o_Double_Click, o_Long_Press, o_Repeat, o_Busy
    );

    modport slave (
        input  i_Switch,
        output o_Click, o_Double_Click, o_Long_Press, o_Repeat, o_Busy
    );

endinterface

// File: rtl/edge_detect.sv
// edge_detect: registered previous level with rise/fall strobes
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   i_Level        : synchronous, debounced level
//   o_Rise, o_Fall : high in the cycle the level differs from last cycle's
module edge_detect (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Level,
    output logic o_Rise,
    output logic o_Fall
);

    logic r_Prev;

    always_ff @(posedge i_Clk or negedge i_Rst_L)
        if (!i_Rst_L) r_Prev <= 1'b0;
        else          r_Prev <= i_Level;

    assign o_Rise = i_Level & ~r_Prev;
    assign o_Fall = ~i_Level & r_Prev;

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies presses into click, double click, long press and repeat
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   bus            : switch level in, registered one-cycle gesture pulses and busy out
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int c_LONG_LIMIT    = 25_000_000,
    parameter int c_DOUBLE_GAP    = 6_250_000,
    parameter int c_REPEAT_PERIOD = 2_500_000
) (
    input logic                   i_Clk,
    input logic                   i_Rst_L,
    button_event_decoder_if.slave bus
);

    localparam int c_CW = cnt_width(c_LONG_LIMIT, c_DOUBLE_GAP, c_REPEAT_PERIOD);

    if (c_LONG_LIMIT < 2)    begin : g_bad_long   $error("c_LONG_LIMIT must be >= 2");    end
    if (c_DOUBLE_GAP < 2)    begin : g_bad_gap    $error("c_DOUBLE_GAP must be >= 2");    end
    if (c_REPEAT_PERIOD < 2) begin : g_bad_repeat $error("c_REPEAT_PERIOD must be >= 2"); end

    t_Button_State r_State, w_State;
    logic [c_CW-1:0] r_Cnt, w_Cnt;
    logic w_Rise, w_Fall;
    logic w_Click, w_Double, w_Long, w_Repeat;

    edge_detect u_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Level (bus.i_Switch),
        .o_Rise  (w_Rise),
        .o_Fall  (w_Fall)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L)
        if (!i_Rst_L) begin
            r_State            <= IDLE;
            r_Cnt              <= '0;
            bus.o_Click        <= 1'b0;
            bus.o_Double_Click <= 1'b0;
            bus.o_Long_Press   <= 1'b0;
            bus.o_Repeat       <= 1'b0;
        end else begin
            r_State            <= w_State;
            r_Cnt              <= w_Cnt;
            bus.o_Click        <= w_Click;
            bus.o_Double_Click <= w_Double;
            bus.o_Long_Press   <= w_Long;
            bus.o_Repeat       <= w_Repeat;
        end

    // Input edges are tested before counter expiry so an edge always wins a tie.
    always_comb begin
        w_State  = r_State;
        w_Cnt    = (r_State == IDLE || r_State == PRESS2) ? '0 : r_Cnt + 1'b1;
        w_Click  = 1'b0;
        w_Double = 1'b0;
        w_Long   = 1'b0;
        w_Repeat = 1'b0;
        case (r_State)
            IDLE:   if (w_Rise) w_State = PRESS1;
            PRESS1: if (w_Fall) w_State = GAP;
                    else if (r_Cnt == c_CW'(c_LONG_LIMIT - 1)) begin
                        w_Long  = 1'b1;
                        w_State = HELD;
                    end
            GAP:    if (w_Rise) begin
                        w_Double = 1'b1;
                        w_State  = PRESS2;
                    end else if (r_Cnt == c_CW'(c_DOUBLE_GAP - 1)) begin
                        w_Click = 1'b1;
                        w_State = IDLE;
                    end
            PRESS2: if (w_Fall) w_State = IDLE;
            HELD:   if (w_Fall) w_State = IDLE;
                    else if (r_Cnt == c_CW'(c_REPEAT_PERIOD - 1)) begin
                        w_Repeat = 1'b1;
                        w_Cnt    = '0;
                    end
            default: w_State = IDLE;
        endcase
        if (w_State != r_State) w_Cnt = '0;
    end

    assign bus.o_Busy = (r_State != IDLE);

endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: table-driven gestures, reset corners and random model comparison
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    button_event_decoder_if bus();

    button_event_decoder #(
        .c_LONG_LIMIT    (20),
        .c_DOUBLE_GAP    (8),
        .c_REPEAT_PERIOD (5)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // {click, double, long, repeat, busy}
    logic [4:0] outs;
    assign outs = {bus.o_Click, bus.o_Double_Click, bus.o_Long_Press, bus.o_Repeat, bus.o_Busy};

    typedef struct {
        bit         sw;
        int         n;
        logic [4:0] exp;
        logic [4:0] msk;
    } vec_t;

    vec_t tbl[$];
    int errors = 0;
    int checks = 0;

    task automatic step(input bit sw);
        @(negedge clk);
        bus.i_Switch = sw;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [4:0] got, input logic [4:0] exp, input logic [4:0] msk);
        checks++;
        if ((got & msk) !== (exp & msk)) begin
            errors++;
            $display("FAIL %s: got %b want %b (mask %b)", nm, got, exp, msk);
        end
    endtask

    task automatic add(input bit sw, input int n, input logic [4:0] exp, input logic [4:0] msk = 5'b11111);
        vec_t v;
        v.sw = sw;
        v.n = n;
        v.exp = exp;
        v.msk = msk;
        tbl.push_back(v);
    endtask

    task automatic run_tbl(input string nm);
        int e = 0;
        foreach (tbl[i])
            for (int k = 0; k < tbl[i].n; k++) begin
                step(tbl[i].sw);
                e++;
                check($sformatf("%s edge %0d", nm, e), outs, tbl[i].exp, tbl[i].msk);
            end
        tbl.delete();
    endtask

    int g, t0, n;
    bit p, lvl, rise, fall;
    logic [4:0] e;

    initial begin
        bus.i_Switch = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("reset state", outs, 5'b00000, 5'b11111);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single click: 5 pressed edges, click 8 edges after the release edge
        add(1, 5, 5'b00001);
        add(0, 1, 5'b00001);
        add(0, 7, 5'b00001);
        add(0, 1, 5'b10000, 5'b11110);
        add(0, 4, 5'b00000);
        run_tbl("single");

        // Double click: press 3, release 4, press 3, release
        add(1, 3, 5'b00001);
        add(0, 4, 5'b00001);
        add(1, 1, 5'b01001);
        add(1, 2, 5'b00001);
        add(0, 12, 5'b00000);
        run_tbl("double");

        // Long press held 38 edges: long at 20, repeats at 25/30/35, no click on release
        add(1, 20, 5'b00001);
        add(1, 1, 5'b00101);
        add(1, 4, 5'b00001);
        add(1, 1, 5'b00011);
        add(1, 4, 5'b00001);
        add(1, 1, 5'b00011);
        add(1, 4, 5'b00001);
        add(1, 1, 5'b00011);
        add(1, 2, 5'b00001);
        add(0, 12, 5'b00000);
        run_tbl("long");

        // Release exactly at long expiry, then press again exactly at gap expiry
        add(1, 20, 5'b00001);
        add(0, 1, 5'b00001);
        add(0, 7, 5'b00001);
        add(1, 1, 5'b01001);
        add(0, 12, 5'b00000);
        run_tbl("boundary");

        // Reset in HELD clears everything without a clock edge
        repeat (25) step(1);
        check("held busy", outs, 5'b00001, 5'b00001);
        rst_n = 1'b0;
        #1 check("async reset", outs, 5'b00000, 5'b11111);
        @(posedge clk);
        #2 rst_n = 1'b1;
        add(1, 1, 5'b00001);
        add(1, 19, 5'b00001);
        add(1, 1, 5'b00101);
        add(0, 1, 5'b00000);
        run_tbl("post-reset");

        // Random gestures against an elapsed-time model
        bus.i_Switch = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        g = 0; t0 = 0; n = 0; p = 0; lvl = 0;
        for (int r = 0; r < 160; r++) begin
            int len;
            len = $urandom_range(1, 28);
            lvl = ~lvl;
            for (int k = 0; k < len; k++) begin
                step(lvl);
                n++;
                rise = lvl & ~p;
                fall = ~lvl & p;
                p = lvl;
                e = '0;
                if (g == 0) begin
                    if (rise) begin g = 1; t0 = n; end
                end else if (g == 1) begin
                    if (fall) begin g = 2; t0 = n; end
                    else if (n - t0 == 20) begin e[2] = 1; g = 4; t0 = n; end
                end else if (g == 2) begin
                    if (rise) begin e[3] = 1; g = 3; end
                    else if (n - t0 == 8) begin e[4] = 1; g = 0; end
                end else if (g == 3) begin
                    if (fall) g = 0;
                end else begin
                    if (fall) g = 0;
                    else if ((n - t0) % 5 == 0) e[1] = 1;
                end
                e[0] = (g != 0);
                check($sformatf("random edge %0d", n), outs, e, 5'b11111);
                checks++;
                if ($countones(outs[4:1]) > 1) begin
                    errors++;
                    $display("FAIL pulse overlap edge %0d: got %b want at most one pulse", n, outs);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
